// File: rtl/reg_file_mp.sv
// ============================================================================
// Module   : reg_file_mp
// Purpose  : Two-read / two-write integer register file with hardwired x0 and
//            a sequential clear engine. Optional same-cycle write->read
//            forwarding is enabled by defining REG_FILE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_mp #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   A1,
    input  logic [AW-1:0]   A2,
    output logic [XLEN-1:0] RD1,
    output logic [XLEN-1:0] RD2,
    input  logic            WE3,
    input  logic [AW-1:0]   A3,
    input  logic [XLEN-1:0] WD3,
    input  logic            WE4,
    input  logic [AW-1:0]   A4,
    input  logic [XLEN-1:0] WD4,
    input  logic            clr_req,
    output logic            clr_busy,
    output logic            clr_done
);

    localparam logic [1:0]    c_IDLE  = 2'd0;
    localparam logic [1:0]    c_CLEAR = 2'd1;
    localparam logic [1:0]    c_DONE  = 2'd2;
    localparam logic [AW-1:0] c_LAST  = AW'(NREG - 1);

    logic [1:0]      r_state;
    logic [AW-1:0]   r_idx;
    logic            w_we3;
    logic            w_we4;
    logic [XLEN-1:0] w_entry [NREG];
    logic [XLEN-1:0] w_rd1;
    logic [XLEN-1:0] w_rd2;

    function automatic logic f_addr_ok(input logic [AW-1:0] a);
        return (a != '0) && (int'(a) < NREG);
    endfunction

    // Write ports are frozen for the whole sweep; the pipeline stalls on clr_busy.
    assign w_we3 = WE3 && f_addr_ok(A3) && (r_state != c_CLEAR);
    assign w_we4 = WE4 && f_addr_ok(A4) && (r_state != c_CLEAR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
            r_idx   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (clr_req) begin
                        r_state <= c_CLEAR;
                        r_idx   <= AW'(1);
                    end
                end
                c_CLEAR: begin
                    if (r_idx == c_LAST) begin
                        r_state <= c_DONE;
                        r_idx   <= '0;
                    end else begin
                        r_idx <= r_idx + AW'(1);
                    end
                end
                c_DONE:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign clr_busy   = (r_state == c_CLEAR);
    assign clr_done   = (r_state == c_DONE);
    assign w_entry[0] = '0;

    generate
        for (genvar k = 1; k < NREG; k++) begin : g_entry
            logic [XLEN-1:0] r_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_q <= '0;
                end else if ((r_state == c_CLEAR) && (r_idx == AW'(k))) begin
                    r_q <= '0;
                end else if (w_we3 && (A3 == AW'(k))) begin
                    r_q <= WD3;
                end else if (w_we4 && (A4 == AW'(k))) begin
                    r_q <= WD4;
                end
            end

            assign w_entry[k] = r_q;
        end
    endgenerate

    // Out-of-range addresses fall through the loop and read as zero.
    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        for (int k = 0; k < NREG; k++) begin
            if (A1 == AW'(k)) w_rd1 = w_entry[k];
            if (A2 == AW'(k)) w_rd2 = w_entry[k];
        end
`ifdef REG_FILE_BYPASS_EN
        if (w_we4 && (A4 == A1)) w_rd1 = WD4;
        if (w_we3 && (A3 == A1)) w_rd1 = WD3;
        if (w_we4 && (A4 == A2)) w_rd2 = WD4;
        if (w_we3 && (A3 == A2)) w_rd2 = WD3;
`else
`endif
    end

    assign RD1 = w_rd1;
    assign RD2 = w_rd2;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_mp.sv
// ============================================================================
// Module   : tb_reg_file_mp
// Purpose  : Self-checking bench for reg_file_mp (reads, dual writes, bypass,
//            clear sweep, reset during sweep).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file_mp;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [AW-1:0]   A1 = '0, A2 = '0, A3 = '0, A4 = '0;
    logic [XLEN-1:0] WD3 = '0, WD4 = '0;
    logic            WE3 = 1'b0, WE4 = 1'b0, clr_req = 1'b0;
    logic [XLEN-1:0] RD1, RD2;
    logic            clr_busy, clr_done;

    int              total  = 0;
    int              passed = 0;
    logic [XLEN-1:0] model [NREG];
    logic [XLEN-1:0] exp1_q [$];
    logic [XLEN-1:0] exp2_q [$];
    logic [XLEN-1:0] e;

    reg_file_mp #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
        .WE3(WE3), .A3(A3), .WD3(WD3),
        .WE4(WE4), .A4(A4), .WD4(WD4),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [XLEN-1:0] fill_val(input int i);
        return 32'hA500_0000 + (i * 32'h0001_0203) + 32'd1;
    endfunction

    // One write cycle; the model applies port 4 first so port 3 wins on a tie.
    task automatic do_write(input logic we3, input logic [AW-1:0] a3, input logic [XLEN-1:0] d3,
                            input logic we4, input logic [AW-1:0] a4, input logic [XLEN-1:0] d4);
        WE3 = we3; A3 = a3; WD3 = d3;
        WE4 = we4; A4 = a4; WD4 = d4;
        tick();
        WE3 = 1'b0; WE4 = 1'b0;
        if (we4 && a4 != '0) model[a4] = d4;
        if (we3 && a3 != '0) model[a3] = d3;
    endtask

    task automatic fill_all();
        for (int i = 1; i < NREG; i += 2) begin
            if (i + 1 < NREG) do_write(1'b1, AW'(i), fill_val(i), 1'b1, AW'(i + 1), fill_val(i + 1));
            else              do_write(1'b1, AW'(i), fill_val(i), 1'b0, '0, '0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < NREG; i++) model[i] = '0;
        total++; if (clr_busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", clr_busy); else passed++;
        total++; if (clr_done !== 1'b0) $display("FAIL reset_done got=%b exp=0", clr_done); else passed++;
        A1 = 5; A2 = 31;
        exp1_q.push_back(model[5]); exp2_q.push_back(model[31]);
        #1;
        e = exp1_q.pop_front(); total++; if (RD1 !== e) $display("FAIL reset_rd1 got=%h exp=%h", RD1, e); else passed++;
        e = exp2_q.pop_front(); total++; if (RD2 !== e) $display("FAIL reset_rd2 got=%h exp=%h", RD2, e); else passed++;
        tick(); tick();
        rst = 1'b1;
        tick();
        do_write(1'b1, '0, 32'hFFFF_FFFF, 1'b0, '0, '0);
        A1 = 0; exp1_q.push_back(model[0]);
        #1;
        e = exp1_q.pop_front(); total++; if (RD1 !== e) $display("FAIL x0_write got=%h exp=%h", RD1, e); else passed++;
    endtask

    task automatic test_single_write();
        do_write(1'b1, 5'd1, 32'h1234_5678, 1'b0, '0, '0);
        A1 = 1; exp1_q.push_back(model[1]);
        #1;
        e = exp1_q.pop_front(); total++; if (RD1 !== e) $display("FAIL wr3_single got=%h exp=%h", RD1, e); else passed++;
        do_write(1'b0, '0, '0, 1'b1, 5'd2, 32'h8765_4321);
        A2 = 2; exp2_q.push_back(model[2]);
        #1;
        e = exp2_q.pop_front(); total++; if (RD2 !== e) $display("FAIL wr4_single got=%h exp=%h", RD2, e); else passed++;
    endtask

    task automatic test_dual_write();
        do_write(1'b1, 5'd7, 32'hAAAA_0000, 1'b1, 5'd7, 32'h5555_FFFF);
        A1 = 7; exp1_q.push_back(32'hAAAA_0000);
        #1;
        e = exp1_q.pop_front(); total++; if (RD1 !== e) $display("FAIL dual_same_addr got=%h exp=%h", RD1, e); else passed++;
        do_write(1'b1, 5'd8, 32'h0808_0808, 1'b1, 5'd9, 32'h0909_0909);
        A1 = 8; A2 = 9; exp1_q.push_back(model[8]); exp2_q.push_back(model[9]);
        #1;
        e = exp1_q.pop_front(); total++; if (RD1 !== e) $display("FAIL dual_a3 got=%h exp=%h", RD1, e); else passed++;
        e = exp2_q.pop_front(); total++; if (RD2 !== e) $display("FAIL dual_a4 got=%h exp=%h", RD2, e); else passed++;
    endtask

    task automatic test_bypass();
        do_write(1'b1, 5'd4, 32'h1111_0000, 1'b0, '0, '0);
        A1 = 4; WE3 = 1'b1; A3 = 4; WD3 = 32'hDEAD_BEEF;
`ifdef REG_FILE_BYPASS_EN
        exp1_q.push_back(32'hDEAD_BEEF);
`else
        exp1_q.push_back(model[4]);
`endif
        #1;
        e = exp1_q.pop_front(); total++; if (RD1 !== e) $display("FAIL same_cycle_read got=%h exp=%h", RD1, e); else passed++;
        tick();
        WE3 = 1'b0; model[4] = 32'hDEAD_BEEF;
        exp1_q.push_back(model[4]);
        #1;
        e = exp1_q.pop_front(); total++; if (RD1 !== e) $display("FAIL after_edge_read got=%h exp=%h", RD1, e); else passed++;
    endtask

    task automatic test_clear_sweep();
        int busy_cnt = 0, done_cnt = 0, done_at = -1;
        fill_all();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int j = 0; j < 40; j++) begin
            if (j > 0) tick();
            if (clr_busy === 1'b1) busy_cnt++;
            if (clr_done === 1'b1) begin done_cnt++; done_at = j; end
            WE3 = (j >= 1 && j <= 5); A3 = 1; WD3 = 32'hBAD0_0001;
            clr_req = (j == 3);
            if (j == 5) begin
                A1 = 2; A2 = 31;
                exp1_q.push_back('0); exp2_q.push_back(model[31]);
                #1;
                e = exp1_q.pop_front(); total++; if (RD1 !== e) $display("FAIL sweep_swept_entry got=%h exp=%h", RD1, e); else passed++;
                e = exp2_q.pop_front(); total++; if (RD2 !== e) $display("FAIL sweep_unswept_entry got=%h exp=%h", RD2, e); else passed++;
            end
        end
        WE3 = 1'b0; clr_req = 1'b0;
        total++; if (busy_cnt != NREG - 1) $display("FAIL sweep_busy_cycles got=%0d exp=%0d", busy_cnt, NREG - 1); else passed++;
        total++; if (done_cnt != 1) $display("FAIL sweep_done_pulses got=%0d exp=1", done_cnt); else passed++;
        total++; if (done_at != NREG - 1) $display("FAIL sweep_done_time got=%0d exp=%0d", done_at, NREG - 1); else passed++;
        for (int i = 0; i < NREG; i++) model[i] = '0;
        for (int i = 0; i < NREG; i++) begin
            A1 = AW'(i); exp1_q.push_back(model[i]);
            #1;
            e = exp1_q.pop_front(); total++; if (RD1 !== e) $display("FAIL sweep_clear_x%0d got=%h exp=%h", i, RD1, e); else passed++;
        end
    endtask

    task automatic test_reset_mid_sweep();
        int done_cnt = 0, busy_cnt = 0;
        fill_all();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (10) tick();
        total++; if (clr_busy !== 1'b1) $display("FAIL midsweep_busy got=%b exp=1", clr_busy); else passed++;
        rst = 1'b0;
        #1;
        total++; if (clr_busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", clr_busy); else passed++;
        total++; if (clr_done !== 1'b0) $display("FAIL abort_done got=%b exp=0", clr_done); else passed++;
        for (int i = 0; i < NREG; i++) model[i] = '0;
        tick(); tick();
        rst = 1'b1;
        for (int j = 0; j < 40; j++) begin
            tick();
            if (clr_done === 1'b1) done_cnt++;
            if (clr_busy === 1'b1) busy_cnt++;
        end
        total++; if (done_cnt != 0) $display("FAIL abort_no_done got=%0d exp=0", done_cnt); else passed++;
        total++; if (busy_cnt != 0) $display("FAIL abort_no_busy got=%0d exp=0", busy_cnt); else passed++;
        for (int i = 1; i < NREG; i++) begin
            A2 = AW'(i); exp2_q.push_back(model[i]);
            #1;
            e = exp2_q.pop_front(); total++; if (RD2 !== e) $display("FAIL abort_clear_x%0d got=%h exp=%h", i, RD2, e); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_dual_write();
        test_bypass();
        test_clear_sweep();
        test_reset_mid_sweep();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
